// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Instruction-fetch initiator. Holds the PC, issues single-cycle
//               fetches to a combinational instruction memory, buffers fetched
//               words in a small FIFO toward decode, and supports redirect
//               with flush and halting on misaligned/out-of-range addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int                PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]       LAST_ADDR = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fifo_data_q [FIFO_DEPTH];
    logic [31:0]        fifo_pc_q   [FIFO_DEPTH];

    logic               bad_addr;
    logic               space;
    logic               push;
    logic               pop;

    // Address check and FIFO handshake terms derived from registered state
    always_comb begin
        bad_addr   = (pc_q[1:0] != 2'b00) || (pc_q > LAST_ADDR);
        inst_valid = (count_q != '0);
        pop        = inst_valid && inst_ready && !redirect_valid;
        space      = (count_q < DEPTH_C) || (inst_valid && inst_ready);
        imem_req   = (state_q == ST_RUN) && !bad_addr && space && !redirect_valid;
        push       = imem_req;
        imem_addr  = pc_q;
        fetch_fault = (state_q == ST_FAULT);
        inst_data  = inst_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
        inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    end

    // Next-state, PC and FIFO bookkeeping; redirect overrides everything
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect_valid) begin
            state_d  = ST_RUN;
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_RUN:   if (bad_addr) state_d = ST_FAULT;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_BOOT;
            endcase

            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, PC and FIFO pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: capture the fetched word and its address on each push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= 32'h0;
                fifo_pc_q[i]   <= 32'h0;
            end
        end else if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_data;
            fifo_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    logic [31:0] mem [32];
    int          n_checks;
    int          n_fail;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (128),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: word i = (i<<20)|(i<<7)|0x13
    assign imem_data = mem[imem_addr[6:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc   [4];
        logic [31:0] exp_data [4];
        exp_pc   = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_data = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
        rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
        n_checks++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h exp 0", inst_data); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", inst_pc); end
        n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got %b exp 0", fetch_fault); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req got %b exp 0", imem_req); end
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_fetch got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL first_fetch_valid got %b exp 0", inst_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] || inst_data !== exp_data[i]) begin
                n_fail++;
                $display("FAIL stream_%0d got v=%b pc=%h d=%h exp v=1 pc=%h d=%h", i, inst_valid, inst_pc, inst_data, exp_pc[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0; inst_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();   // RUN, fetching pc 0
        step();   // one entry, fetching pc 4
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL bp_second_fetch got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h00000013) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got req=%b v=%b pc=%h d=%h exp req=0 v=1 pc=0 d=00000013", i, imem_req, inst_valid, inst_pc, inst_data);
            end
        end
        inst_ready = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_release_req got req=%b addr=%h exp req=1 addr=8", imem_req, imem_addr); end
        step();
        n_checks++; if (inst_pc !== 32'h4 || inst_data !== 32'h00100093) begin n_fail++; $display("FAIL bp_pc4 got pc=%h d=%h exp pc=4 d=00100093", inst_pc, inst_data); end
        step();
        n_checks++; if (inst_pc !== 32'h8 || inst_data !== 32'h00200113) begin n_fail++; $display("FAIL bp_pc8 got pc=%h d=%h exp pc=8 d=00200113", inst_pc, inst_data); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req got %b exp 0", imem_req); end
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got v=%b exp 0", inst_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_fetch got req=%b addr=%h exp req=1 addr=40", imem_req, imem_addr); end
        step();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== 32'h01000813) begin n_fail++; $display("FAIL redir_head got v=%b pc=%h d=%h exp v=1 pc=40 d=01000813", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req got %b exp 0", imem_req); end
        step();
        n_checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_fault got f=%b req=%b exp f=1 req=0", fetch_fault, imem_req); end
        step(); step();
        n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL mis_persist got %b exp 1", fetch_fault); end
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL clr_req got %b exp 0", imem_req); end
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL clr_fetch got f=%b req=%b addr=%h exp f=0 req=1 addr=10", fetch_fault, imem_req, imem_addr); end
        step();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst_data !== 32'h00400213) begin n_fail++; $display("FAIL clr_head got v=%b pc=%h d=%h exp v=1 pc=10 d=00400213", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_boundary();
        inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h78;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h78) begin n_fail++; $display("FAIL bnd_78 got req=%b addr=%h exp req=1 addr=78", imem_req, imem_addr); end
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h7C) begin n_fail++; $display("FAIL bnd_7c got req=%b addr=%h exp req=1 addr=7c", imem_req, imem_addr); end
        step();
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL bnd_80_req got req=%b addr=%h exp req=0 addr=80", imem_req, imem_addr); end
        step();
        n_checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL bnd_fault got f=%b req=%b exp f=1 req=0", fetch_fault, imem_req); end
        n_checks++; if (inst_pc !== 32'h78 || inst_data !== 32'h01E00F13) begin n_fail++; $display("FAIL bnd_head got pc=%h d=%h exp pc=78 d=01e00f13", inst_pc, inst_data); end
        inst_ready = 1'b1;
        step();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h7C || inst_data !== 32'h01F00F93 || fetch_fault !== 1'b1) begin n_fail++; $display("FAIL bnd_drain got v=%b pc=%h d=%h f=%b exp v=1 pc=7c d=01f00f93 f=1", inst_valid, inst_pc, inst_data, fetch_fault); end
        step();
        n_checks++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || fetch_fault !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL bnd_empty got v=%b d=%h f=%b req=%b exp v=0 d=0 f=1 req=0", inst_valid, inst_data, fetch_fault, imem_req); end
    endtask

    task automatic test_reset_mid();
        inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        step(); step();
        n_checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_pc !== 32'h20) begin n_fail++; $display("FAIL mid_full got v=%b req=%b pc=%h exp v=1 req=0 pc=20", inst_valid, imem_req, inst_pc); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0 || fetch_fault !== 1'b0 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst got v=%b f=%b pc=%h addr=%h exp all 0", inst_valid, fetch_fault, inst_pc, imem_addr); end
        step();
        rst_n = 1'b1;
        inst_ready = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_boot got req=%b exp 0", imem_req); end
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
        end
        rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #2;
        test_reset();
        test_backpressure();
        test_redirect();
        test_fault();
        test_boundary();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory interface. Holds the PC, drives imem_req/imem_addr into the combinational instruction memory, and captures imem_data the same cycle. Fetched words go into a small FIFO with valid/ready toward decode. Supports control-flow redirect with flush and fault detection for misaligned or out-of-range fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
IMEM_BYTES, 128, byte size of instruction memory (2**7).
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory (combinational)
imem_addr  output  32  byte address of fetch, equals pc
imem_data  input  32  instruction word, valid same cycle as imem_req
redirect_valid  input  1  load new PC and flush buffer
redirect_pc  input  32  redirect target
inst_valid  output  1  FIFO head holds an instruction
inst_ready  input  1  decode accepts head
inst_data  output  32  head instruction word
inst_pc  output  32  address of head instruction
fetch_fault  output  1  fetch halted on bad address

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, state=BOOT, FIFO empty (count=0, pointers 0), inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0, imem_req=0, imem_addr=RESET_PC.
- States: BOOT, RUN, FAULT.
  - BOOT: imem_req=0 for one cycle, then RUN. Absorbs reset deassertion.
  - RUN: bad = (pc[1:0]!=0) or (pc > IMEM_BYTES-4). If bad, no request and next state FAULT. Otherwise fetch when space = (count<FIFO_DEPTH) or (inst_valid and inst_ready).
  - FAULT: imem_req=0 and fetch_fault=1. Already-buffered entries still drain. Leaves only on redirect_valid.
- Fetch: imem_req=1 and imem_addr=pc, combinational from the registered state. At the clock edge, push {imem_data, pc} and set pc=pc+4 (32-bit wrap).
- Pop: when inst_valid and inst_ready, the head is removed at the edge. Push and pop in the same cycle leave count unchanged.
- FIFO outputs come from the registered head: inst_data and inst_pc hold while inst_valid=1 and inst_ready=0. Both read 0 when empty.
- Throughput: one instruction per cycle steady state. First inst_valid appears 2 cycles after rst_n rises (BOOT, then fetch).
- Redirect (highest priority, any state):
  - imem_req forced 0 that cycle.
  - At the edge: FIFO flushed (any pop that cycle is discarded), pc=redirect_pc, state=RUN, fetch_fault cleared.
  - The next fetch is from redirect_pc in the following cycle.
- Simultaneous events: redirect beats push and pop. Fault detection beats push. A push into a full FIFO happens only with a concurrent pop.
- Reset mid-operation: immediate return to reset values regardless of state. In-flight data is dropped.
- Invariants: count never exceeds FIFO_DEPTH. inst_pc entries are always 4-byte aligned.

Test Plan:
- Reset, mem[0..15] = words 0x00000013, 0x00100093, 0x00200113, 0x00300193, with inst_ready=1 -> inst_valid rises 2 cycles after rst_n. Outputs are (pc 0, 0x00000013), (4, 0x00100093), (8, 0x00200113), (12, 0x00300193), one per cycle.
- inst_ready=0 for 5 cycles after the first fetch -> count saturates at 2 and imem_req=0 while full. Head stays (0, 0x00000013). After release, pcs 0, 4, 8 arrive in order with no loss or duplication.
- redirect_valid=1, redirect_pc=0x40 while the FIFO holds pcs 8 and 12 -> imem_req=0 that cycle and the next inst_valid cycle shows inst_pc=0x40. Old entries are never presented.
- redirect_pc=0x42 -> the cycle after redirect shows imem_req=0, then fetch_fault=1 persists. A later redirect to 0x10 clears the fault and fetches 0x10.
- Sequential run to pc=0x7C then 0x80 with IMEM_BYTES=128 -> 0x7C is fetched. At 0x80 fetch_fault=1, no request, and the 0x7C entry still drains.
- rst_n pulsed low mid-stream with FIFO full -> inst_valid=0 and fetch_fault=0 immediately. Fetch restarts at RESET_PC after BOOT.
